uc_pila: RTL

- Sequencing control unit for the single-cycle microcontroller datapath. It replaces the purely combinational decoder.
- Decodes the 6-bit Opcode and the registered zero flag z into s_inc, s_inm, we3, wez and Op.
- Adds a hardware return-address stack for CALL/RET, a run/halt/single-step debug state machine and a sticky error trap.
- The datapath gains two inputs, pc_en and s_ret, plus a ret_addr path into the PC mux.

---
 rtl/uc_pila_pkg.sv | 93 +++++++++
 rtl/uc_pila_pila_ret.sv | 52 +++++
 rtl/uc_pila.sv | 120 ++++++++++++
 3 files changed

// File: rtl/uc_pila_pkg.sv
// uc_pila shared definitions: opcode map, ALU op codes, FSM encoding
// and the pure instruction decoder used by the sequencing unit.
package uc_pila_pkg;

    localparam logic [5:0] OP_J    = 6'b100000;
    localparam logic [5:0] OP_JZ   = 6'b100001;
    localparam logic [5:0] OP_JNZ  = 6'b100010;
    localparam logic [5:0] OP_CALL = 6'b100011;
    localparam logic [5:0] OP_RET  = 6'b100100;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [1:0] CLS_RR = 2'b00;
    localparam logic [1:0] CLS_RI = 2'b01;

    localparam logic [2:0] ALU_NONE = 3'b000;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HALT = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    typedef struct packed {
        logic       s_inc;
        logic       s_ret;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op;
        logic       pc_en;
        logic       push;
        logic       pop;
        logic       fault;
        logic       stop;
    } dec_t;

    // Decode assuming the instruction is allowed to execute this cycle.
    function automatic dec_t decode(
        input logic [5:0] opc,
        input logic       zf,
        input logic       full,
        input logic       empty
    );
        dec_t d;
        d       = '0;
        d.op    = ALU_NONE;
        d.s_inc = 1'b1;
        d.pc_en = 1'b1;
        unique case (1'b1)
            opc[5:4] == CLS_RR: begin
                d.op  = opc[3:1];
                d.we3 = 1'b1;
                d.wez = 1'b1;
            end
            opc[5:4] == CLS_RI: begin
                d.op    = opc[3:1];
                d.s_inm = 1'b1;
                d.we3   = 1'b1;
                d.wez   = 1'b1;
            end
            opc == OP_J:   d.s_inc = 1'b0;
            opc == OP_JZ:  d.s_inc = !zf;
            opc == OP_JNZ: d.s_inc = zf;
            opc == OP_CALL: begin
                if (full) begin
                    d.fault = 1'b1;
                end else begin
                    d.s_inc = 1'b0;
                    d.push  = 1'b1;
                end
            end
            opc == OP_RET: begin
                if (empty) begin
                    d.fault = 1'b1;
                end else begin
                    d.s_ret = 1'b1;
                    d.pop   = 1'b1;
                end
            end
            opc == OP_HALT: begin
                d.pc_en = 1'b0;
                d.stop  = 1'b1;
            end
            default: ;
        endcase
        // A stack fault freezes the PC on the offending instruction.
        if (d.fault) begin
            d.pc_en = 1'b0;
            d.s_inc = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/uc_pila_pila_ret.sv
// Return-address LIFO: DEPTH entries of AW bits, occupancy counter
// with full/empty flags; guarded push/pop never corrupt the pointer.
module pila_ret #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [AW-1:0]            din,
    output logic [AW-1:0]            top,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     full,
    output logic                     empty
);
    localparam int IW = $clog2(DEPTH);
    localparam int SW = IW + 1;

    logic [AW-1:0] mem [DEPTH];
    logic [SW-1:0] cnt;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic          do_push;
    logic          do_pop;

    assign wr_idx  = cnt[IW-1:0];
    assign rd_idx  = wr_idx - IW'(1);
    assign full    = (cnt == SW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign top     = mem[rd_idx];
    assign sp      = cnt;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (do_push) begin
            cnt <= cnt + SW'(1);
        end else if (do_pop) begin
            cnt <= cnt - SW'(1);
        end
    end

endmodule

// File: rtl/uc_pila.sv
// Sequencing control unit: instruction decode, return stack,
// run/halt/step debug FSM and sticky error trap.
module uc_pila
    import uc_pila_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int AW       = 10,
    parameter int BOOT_RUN = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             opcode,
    input  logic                   z,
    input  logic [AW-1:0]          pc_plus1,
    input  logic                   halt_req,
    input  logic                   run,
    input  logic                   step,
    output logic                   s_inc,
    output logic                   s_ret,
    output logic [AW-1:0]          ret_addr,
    output logic                   s_inm,
    output logic                   we3,
    output logic                   wez,
    output logic [2:0]             op,
    output logic                   pc_en,
    output logic                   halted,
    output logic                   err,
    output logic [$clog2(DEPTH):0] sp
);
    localparam logic [1:0] ST_BOOT = (BOOT_RUN != 0) ? ST_RUN : ST_HALT;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic          exec;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [AW-1:0] top;
    dec_t          d;

    pila_ret #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_pila (
        .clk  (clk),
        .rst_n(reset),
        .push (push),
        .pop  (pop),
        .din  (pc_plus1),
        .top  (top),
        .sp   (sp),
        .full (full),
        .empty(empty)
    );

    // A pending halt request pre-empts the instruction in RUN.
    assign exec = ((state == ST_RUN) && !halt_req) || (state == ST_STEP);
    assign d    = decode(opcode, z, full, empty);

    assign ret_addr = empty ? '0 : top;
    assign halted   = (state == ST_HALT);
    assign err      = (state == ST_ERR);

    always_comb begin
        op    = d.op;
        s_inm = d.s_inm;
        s_inc = 1'b1;
        s_ret = 1'b0;
        we3   = 1'b0;
        wez   = 1'b0;
        pc_en = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        if (exec) begin
            s_inc = d.s_inc;
            s_ret = d.s_ret;
            we3   = d.we3;
            wez   = d.wez;
            pc_en = d.pc_en;
            push  = d.push;
            pop   = d.pop;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN: begin
                if (halt_req) begin
                    state_nx = ST_HALT;
                end else if (d.fault) begin
                    state_nx = ST_ERR;
                end else if (d.stop) begin
                    state_nx = ST_HALT;
                end
            end
            ST_HALT: begin
                if (halt_req) begin
                    state_nx = ST_HALT;
                end else if (step) begin
                    state_nx = ST_STEP;
                end else if (run) begin
                    state_nx = ST_RUN;
                end
            end
            ST_STEP: state_nx = d.fault ? ST_ERR : ST_HALT;
            default: state_nx = ST_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nx;
        end
    end

endmodule
